// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - memory-stage, data-memory and register-file signals of the writeback stage
interface wb_stage_if #(
  parameter int BIT     = 32,
  parameter int REG_NUM = 32
);
  localparam int AW = $clog2(REG_NUM);

  logic           in_valid;
  logic           in_ready;
  logic [AW-1:0]  in_rd;
  logic           in_rd_we;
  logic           in_is_load;
  logic [2:0]     in_funct3;
  logic [1:0]     in_addr_lo;
  logic [BIT-1:0] in_alu_result;
  logic           mem_rvalid;
  logic [BIT-1:0] mem_rdata;
  logic [AW-1:0]  wb_write;
  logic [BIT-1:0] wb_data;
  logic           wb_we;
  logic           pend_valid;
  logic [AW-1:0]  pend_rd;
  logic [31:0]    retire_cnt;

  modport master (
    output in_valid, in_rd, in_rd_we, in_is_load, in_funct3, in_addr_lo, in_alu_result,
    output mem_rvalid, mem_rdata,
    input  in_ready, wb_write, wb_data, wb_we, pend_valid, pend_rd, retire_cnt
  );

  modport slave (
    input  in_valid, in_rd, in_rd_we, in_is_load, in_funct3, in_addr_lo, in_alu_result,
    input  mem_rvalid, mem_rdata,
    output in_ready, wb_write, wb_data, wb_we, pend_valid, pend_rd, retire_cnt
  );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: load alignment/extension, register file write port, retire counter
module wb_stage #(
  parameter int BIT     = 32,
  parameter int REG_NUM = 32
) (
  input  logic         clk,
  input  logic         rst,
  wb_stage_if.slave    bus
);
  localparam int AW = $clog2(REG_NUM);

  typedef enum logic [1:0] {EMPTY, WAIT_MEM, WRITE} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic           rd_we_q, rd_we_d;
  logic [2:0]     funct3_q, funct3_d;
  logic [1:0]     addr_lo_q, addr_lo_d;
  logic [BIT-1:0] data_q, data_d;
  logic           wb_we_q, wb_we_d;
  logic           pend_valid_q, pend_valid_d;
  logic [31:0]    retire_cnt_q, retire_cnt_d;
  logic           in_ready;
  logic           accept;

  function automatic logic [BIT-1:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [BIT-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    // Misaligned halfwords fall back to the enclosing aligned half.
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{(BIT-8){b[7]}}, b};
      3'b001:  fmt_load = {{(BIT-16){h[15]}}, h};
      3'b100:  fmt_load = {{(BIT-8){1'b0}}, b};
      3'b101:  fmt_load = {{(BIT-16){1'b0}}, h};
      default: fmt_load = w;
    endcase
  endfunction

  assign in_ready = (state_q == EMPTY) || (state_q == WRITE);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    rd_we_d      = rd_we_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    data_d       = data_q;
    wb_we_d      = 1'b0;
    pend_valid_d = 1'b0;
    retire_cnt_d = (state_q == WRITE) ? retire_cnt_q + 32'd1 : retire_cnt_q;

    case (state_q)
      EMPTY, WRITE: begin
        if (accept) begin
          rd_d      = bus.in_rd;
          rd_we_d   = bus.in_rd_we;
          funct3_d  = bus.in_funct3;
          addr_lo_d = bus.in_addr_lo;
          data_d    = bus.in_alu_result;
          if (bus.in_is_load) begin
            state_d      = WAIT_MEM;
            pend_valid_d = bus.in_rd_we && (bus.in_rd != '0);
          end else begin
            state_d = WRITE;
            wb_we_d = bus.in_rd_we && (bus.in_rd != '0);
          end
        end else begin
          state_d = EMPTY;
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          data_d  = fmt_load(funct3_q, addr_lo_q, bus.mem_rdata);
          state_d = WRITE;
          wb_we_d = rd_we_q && (rd_q != '0);
        end else begin
          pend_valid_d = rd_we_q && (rd_q != '0);
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EMPTY;
      rd_q         <= '0;
      rd_we_q      <= 1'b0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      data_q       <= '0;
      wb_we_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      rd_we_q      <= rd_we_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      data_q       <= data_d;
      wb_we_q      <= wb_we_d;
      pend_valid_q <= pend_valid_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.wb_write   = rd_q;
  assign bus.wb_data    = data_q;
  assign bus.wb_we      = wb_we_q;
  assign bus.pend_valid = pend_valid_q;
  assign bus.pend_rd    = rd_q;
  assign bus.retire_cnt = retire_cnt_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage with directed and random instruction streams
module tb_wb_stage;
  localparam int BIT = 32, REG_NUM = 32, AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_stage_if #(.BIT(BIT), .REG_NUM(REG_NUM)) bus ();
  wb_stage #(.BIT(BIT), .REG_NUM(REG_NUM)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [36:0] sb[$];
  logic [31:0] model_cnt = 0;
  int          cyc = 0;
  int          last_wr = -10, prev_wr = -10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * (lo / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && bus.wb_we) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: wb_write=%0d wb_data=0x%08h, no write expected",
                 bus.wb_write, bus.wb_data);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("wb_write", {27'b0, bus.wb_write}, {27'b0, e[36:32]});
        chk("wb_data", bus.wb_data, e[31:0]);
      end
      prev_wr = last_wr;
      last_wr = cyc;
    end
  end

  task automatic issue(input logic [AW-1:0] rd, input logic we, input logic ld,
                       input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] alu,
                       input logic [31:0] rdata, input int delay);
    int waitc = 0;
    @(negedge clk);
    bus.in_rd = rd; bus.in_rd_we = we; bus.in_is_load = ld; bus.in_funct3 = f3;
    bus.in_addr_lo = lo; bus.in_alu_result = alu; bus.in_valid = 1'b1;
    while (!bus.in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready=0 for %0d cycles, expected 1", waitc);
      bus.in_valid = 1'b0;
      return;
    end
    if (we && rd != 0) sb.push_back({rd, ld ? model_load(f3, lo, rdata) : alu});
    model_cnt++;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    if (ld) begin
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        chk("pend_valid", {31'b0, bus.pend_valid}, {31'b0, we && rd != 0});
        chk("pend_rd", {27'b0, bus.pend_rd}, {27'b0, rd});
        chk("in_ready_wait", {31'b0, bus.in_ready}, 32'd0);
        if (i == delay - 1) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rdata;
        end
      end
      @(posedge clk);
      #1 bus.mem_rvalid = 1'b0;
      bus.mem_rdata = $urandom;
    end
  endtask

  task automatic settle_and_count(input string name);
    repeat (2) @(negedge clk);
    chk(name, bus.retire_cnt, model_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 0; bus.in_rd = 0; bus.in_rd_we = 0; bus.in_is_load = 0;
    bus.in_funct3 = 0; bus.in_addr_lo = 0; bus.in_alu_result = 0;
    bus.mem_rvalid = 0; bus.mem_rdata = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wb_we", {31'b0, bus.wb_we}, 32'd0);
    chk("rst_wb_write", {27'b0, bus.wb_write}, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_pend_valid", {31'b0, bus.pend_valid}, 32'd0);
    chk("rst_pend_rd", {27'b0, bus.pend_rd}, 32'd0);
    chk("rst_retire_cnt", bus.retire_cnt, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Back-to-back ALU retirements
    issue(5'd5, 1, 0, 3'd0, 2'd0, 32'h11, 32'h0, 1);
    issue(5'd6, 1, 0, 3'd0, 2'd0, 32'h22, 32'h0, 1);
    settle_and_count("b2b_retire_cnt");
    chk("b2b_consecutive", prev_wr + 1, last_wr);

    issue(5'd9, 1, 1, 3'b000, 2'd3, 32'h0, 32'h80FF_0000, 3);
    issue(5'd10, 1, 1, 3'b101, 2'd2, 32'h0, 32'h9234_5678, 1);
    issue(5'd11, 1, 1, 3'b001, 2'd2, 32'h0, 32'h9234_5678, 2);
    issue(5'd12, 1, 1, 3'b010, 2'd0, 32'h0, 32'h9234_5678, 1);
    issue(5'd13, 1, 1, 3'b001, 2'd1, 32'h0, 32'h0000_8001, 1);
    settle_and_count("load_retire_cnt");

    issue(5'd0, 1, 0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 1);
    issue(5'd7, 0, 0, 3'd0, 2'd0, 32'hCAFE_F00D, 32'h0, 1);
    settle_and_count("nowrite_retire_cnt");

    // Spurious response while empty, then a load abandoned by reset
    @(negedge clk);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("spur_pend_valid", {31'b0, bus.pend_valid}, 32'd0);
    chk("spur_in_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.in_rd = 5'd7; bus.in_rd_we = 1; bus.in_is_load = 1; bus.in_funct3 = 3'b010;
    bus.in_addr_lo = 0; bus.in_valid = 1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_pend_before", {31'b0, bus.pend_valid}, 32'd1);
    rst = 1'b0;
    model_cnt = 0;
    #2;
    chk("abort_pend_in_rst", {31'b0, bus.pend_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hAAAA_5555;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_pend_after", {31'b0, bus.pend_valid}, 32'd0);
    chk("abort_retire_cnt", bus.retire_cnt, 32'd0);
    chk("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Counter wrap
    @(negedge clk);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retire_cnt_q;
    chk("wrap_preload", bus.retire_cnt, 32'hFFFF_FFFF);
    model_cnt = 32'hFFFF_FFFF;
    issue(5'd3, 1, 0, 3'd0, 2'd0, 32'h3333, 32'h0, 1);
    settle_and_count("wrap_retire_cnt");

    for (int n = 0; n < 300; n++) begin
      issue(5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom,
            $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("rand_retire_cnt", bus.retire_cnt, model_cnt);
    chk("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
